// File: rtl/cursor_bitmap_loader_pkg.sv
// Shared types and constants for the cursor bitmap write path.
package cursor_pkg;

    localparam int unsigned CURSOR_ADDR_WIDTH = 10;
    localparam int unsigned CURSOR_DATA_WIDTH = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } loader_state_t;

    // Number of pixels carried by one packed input word.
    function automatic int unsigned ppw(input int unsigned word_w, input int unsigned data_w);
        return word_w / data_w;
    endfunction

endpackage

// File: rtl/cursor_bitmap_loader.sv
// Unpacks MMIO words into per-pixel writes to the cursor bitmap RAM.
module cursor_bitmap_loader
    import cursor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CURSOR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CURSOR_DATA_WIDTH,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ptr_load,
    input  logic [ADDR_WIDTH-1:0] ptr_val,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_word,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned PPW   = ppw(WORD_WIDTH, DATA_WIDTH);
    localparam int unsigned CNT_W = (PPW > 1) ? $clog2(PPW) : 1;

    // A word must split into a whole number of pixels.
    if ((WORD_WIDTH % DATA_WIDTH) != 0) begin : g_bad_word_width
        $error("WORD_WIDTH must be an integer multiple of DATA_WIDTH");
    end

    loader_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   frame_done_q, frame_done_d;

    // State, pointer, shifter and frame pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: pointer load has priority over accepting a word in IDLE.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        wr_ready     = 1'b0;
        frame_done_d = (state_q == UNPACK) && (ptr_q == {ADDR_WIDTH{1'b1}});
        case (state_q)
            IDLE: begin
                wr_ready = reset_n & ~ptr_load;
                if (ptr_load) begin
                    ptr_d = ptr_val;
                end else if (wr_valid) begin
                    shift_d = wr_word;
                    cnt_d   = '0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                shift_d = shift_q >> DATA_WIDTH;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PPW - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port and status are decoded from registers only.
    assign ram_we     = (state_q == UNPACK);
    assign busy       = (state_q == UNPACK);
    assign ram_addr_w = ptr_q;
    assign ram_din    = shift_q[DATA_WIDTH-1:0];
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cursor_bitmap_loader.sv
// Directed self-checking bench for cursor_bitmap_loader.
module tb_cursor_bitmap_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ptr_load;
    logic [9:0]  ptr_val;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_word;
    logic        ram_we;
    logic [9:0]  ram_addr_w;
    logic [1:0]  ram_din;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  mem [1024];
    logic [1:0]  exp_img [1024];
    int          n_writes = 0;
    int          n_frames = 0;
    int          cyc = 0;

    cursor_bitmap_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ptr_load   (ptr_load),
        .ptr_val    (ptr_val),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_word    (wr_word),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural cursor RAM plus write/frame/cycle counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr_w] <= ram_din;
            n_writes <= n_writes + 1;
        end
        if (frame_done) n_frames <= n_frames + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] imgw(input int j);
        return (32'(j) * 32'h9E3779B9) ^ 32'hC3A5_5A3C;
    endfunction

    initial begin
        int n;
        int c0;
        int c1;
        int w0;
        int mism;
        logic [31:0] w;

        for (int i = 0; i < 1024; i++) mem[i] = 2'd0;
        reset_n  = 1'b0;
        ptr_load = 1'b0;
        ptr_val  = '0;
        wr_valid = 1'b0;
        wr_word  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",    32'(ram_we), 32'd0);
        chk("rst_addr",  32'(ram_addr_w), 32'd0);
        chk("rst_din",   32'(ram_din), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_frame", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(wr_ready), 32'd1);

        // 1: single word at address 0
        wr_word  = 32'hE4E4E4E4;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t1_we",    32'(ram_we), 32'd1);
            chk("t1_addr",  32'(ram_addr_w), 32'(i));
            chk("t1_din",   32'(ram_din), 32'(i % 4));
            chk("t1_ready", 32'(wr_ready), 32'd0);
            tick();
        end
        chk("t1_ready_back", 32'(wr_ready), 32'd1);
        chk("t1_we_off",     32'(ram_we), 32'd0);
        chk("t1_busy_off",   32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) chk("t1_ram", 32'(mem[i]), 32'(i % 4));

        // 2: wrap across the top of the bitmap
        ptr_load = 1'b1;
        ptr_val  = 10'h3F8;
        tick();
        ptr_load = 1'b0;
        wr_word  = 32'hFFFFFFFF;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t2_addr",  32'(ram_addr_w), 32'((10'h3F8 + i) & 10'h3FF));
            chk("t2_din",   32'(ram_din), 32'd3);
            chk("t2_frame", 32'(frame_done), (i == 8) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t2_frame_after", 32'(frame_done), 32'd0);
        chk("t2_frame_count", 32'(n_frames), 32'd1);

        // 3: load beats a simultaneous valid
        ptr_load = 1'b1;
        ptr_val  = 10'h123;
        wr_valid = 1'b1;
        wr_word  = 32'hFFFF_0000;
        #1;
        chk("t3_ready_low", 32'(wr_ready), 32'd0);
        tick();
        ptr_load = 1'b0;
        chk("t3_not_taken", 32'(busy), 32'd0);
        wr_word = 32'h0000_0001;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t3_addr", 32'(ram_addr_w), 32'(10'h123 + i));
            chk("t3_din",  32'(ram_din), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // 4: full frame with valid held high
        for (int j = 0; j < 64; j++) begin
            w = imgw(j);
            for (int p = 0; p < 16; p++) exp_img[j*16 + p] = w[p*2 +: 2];
        end
        ptr_load = 1'b1;
        ptr_val  = 10'h000;
        tick();
        ptr_load = 1'b0;
        w0 = n_writes;
        n = n_frames;
        c0 = 0;
        c1 = 0;
        for (int j = 0; j < 64; j++) begin
            wr_word  = imgw(j);
            wr_valid = 1'b1;
            #1;
            mism = 0;
            while (!wr_ready && mism < 40) begin
                tick();
                mism++;
            end
            chk("t4_wait", 32'(mism < 40), 32'd1);
            if (j == 0) c0 = cyc;
            if (j == 63) c1 = cyc;
            tick();
        end
        wr_valid = 1'b0;
        repeat (18) tick();
        chk("t4_cycles", 32'(c1 - c0), 32'(63 * 17));
        chk("t4_writes", 32'(n_writes - w0), 32'd1024);
        chk("t4_frames", 32'(n_frames - n), 32'd1);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_img[i]) mism++;
        chk("t4_image", 32'(mism), 32'd0);

        // 5: reset during the fifth pixel
        ptr_load = 1'b1;
        ptr_val  = 10'h040;
        tick();
        ptr_load = 1'b0;
        wr_word  = 32'h0000_03FF;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        chk("t5_px4_we",   32'(ram_we), 32'd1);
        chk("t5_px4_addr", 32'(ram_addr_w), 32'h044);
        chk("t5_px4_din",  32'(ram_din), 32'd3);
        w0 = n_writes;
        reset_n = 1'b0;
        #1;
        chk("t5_we_drop",   32'(ram_we), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        repeat (2) tick();
        chk("t5_no_writes", 32'(n_writes - w0), 32'd0);
        for (int i = 0; i < 4; i++) chk("t5_kept", 32'(mem[10'h040 + i]), 32'd3);
        mism = 0;
        for (int i = 4; i < 16; i++) if (mem[10'h040 + i] !== exp_img[10'h040 + i]) mism++;
        chk("t5_untouched", 32'(mism), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("t5_ptr",   32'(ram_addr_w), 32'd0);
        chk("t5_ready", 32'(wr_ready), 32'd1);
        chk("t5_busy",  32'(busy), 32'd0);

        // 6: wr_word changes during unpack are ignored
        wr_word  = 32'h1B1B1B1B;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_word = ~(32'h1B1B1B1B) ^ 32'(i * 32'h01010101);
            chk("t6_addr", 32'(ram_addr_w), 32'(i));
            chk("t6_din",  32'(ram_din), 32'(3 - (i % 4)));
            tick();
        end
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
